pcie_tx_arbiter: RTL and testbench

//  Shares the PCIe core transmit AXI-stream (s_axis_tx_*) between two user TLP sources:

---
 rtl/pcie_tx_arbiter_if.sv | 50 +++++
 rtl/pcie_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_arbiter_if.sv
// Bundles both user TLP sources, the core transmit stream and the config handshake.
// The arbiter connects through modport master (it drives the core-side stream); the environment uses slave.
interface pcie_tx_arbiter_if;
    logic [63:0] cpl_tdata;
    logic [7:0]  cpl_tkeep;
    logic        cpl_tlast;
    logic [3:0]  cpl_tuser;
    logic        cpl_tvalid;
    logic        cpl_tready;

    logic [63:0] mwr_tdata;
    logic [7:0]  mwr_tkeep;
    logic        mwr_tlast;
    logic [3:0]  mwr_tuser;
    logic        mwr_tvalid;
    logic        mwr_tready;

    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic [3:0]  s_axis_tx_tuser;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;

    logic        tx_cfg_req;
    logic        tx_cfg_gnt;
    logic        tx_err;

    modport master (
        input  cpl_tdata, cpl_tkeep, cpl_tlast, cpl_tuser, cpl_tvalid,
        output cpl_tready,
        input  mwr_tdata, mwr_tkeep, mwr_tlast, mwr_tuser, mwr_tvalid,
        output mwr_tready,
        output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tuser, s_axis_tx_tvalid,
        input  s_axis_tx_tready,
        input  tx_cfg_req,
        output tx_cfg_gnt, tx_err
    );

    modport slave (
        output cpl_tdata, cpl_tkeep, cpl_tlast, cpl_tuser, cpl_tvalid,
        input  cpl_tready,
        output mwr_tdata, mwr_tkeep, mwr_tlast, mwr_tuser, mwr_tvalid,
        input  mwr_tready,
        input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tuser, s_axis_tx_tvalid,
        output s_axis_tx_tready,
        output tx_cfg_req,
        input  tx_cfg_gnt, tx_err
    );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// Shares the PCIe core TX stream between completion (cpl) and master-request (mwr) TLP sources plus core config traffic.
// Latency: one cycle from IDLE to grant, then zero-latency combinational mux; one idle bubble between TLPs.
// Backpressure: core tready passes straight to the granted source only; PCIE_TX_ARB_STRICT_CPL_EN makes cpl win every tie.
module pcie_tx_arbiter #(
    parameter int MAX_BEATS = 130
) (
    input  logic               user_clk,
    input  logic               user_reset_n,
    pcie_tx_arbiter_if.master  tx
);

    localparam int CNT_W = $clog2(MAX_BEATS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

    typedef enum logic [1:0] {IDLE, CFG, CPL, MWR} state_t;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        logic [3:0]  tuser;
    } beat_t;

    state_t           state_q, state_d;
    logic             last_mwr_q, last_mwr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_q;
    logic             err_q, err_d;

    beat_t cpl_beat, mwr_beat, out_beat;
    logic  out_vld, out_fire, cpl_rdy, mwr_rdy;

    assign cpl_beat = {tx.cpl_tdata, tx.cpl_tkeep, tx.cpl_tlast, tx.cpl_tuser};
    assign mwr_beat = {tx.mwr_tdata, tx.mwr_tkeep, tx.mwr_tlast, tx.mwr_tuser};

    // Datapath: only the granted source reaches the core; everything else reads as zero.
    always_comb begin
        out_beat = '0;
        out_vld  = 1'b0;
        cpl_rdy  = 1'b0;
        mwr_rdy  = 1'b0;
        case (state_q)
            CPL: begin
                out_beat = cpl_beat;
                out_vld  = tx.cpl_tvalid;
                cpl_rdy  = tx.s_axis_tx_tready;
            end
            MWR: begin
                out_beat = mwr_beat;
                out_vld  = tx.mwr_tvalid;
                mwr_rdy  = tx.s_axis_tx_tready;
            end
            default: ;
        endcase
    end

    assign out_fire = out_vld & tx.s_axis_tx_tready;

    always_comb begin
        state_d    = state_q;
        last_mwr_d = last_mwr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (tx.tx_cfg_req)
                    state_d = CFG;
                else if (tx.cpl_tvalid && !tx.mwr_tvalid)
                    state_d = CPL;
                else if (tx.mwr_tvalid && !tx.cpl_tvalid)
                    state_d = MWR;
                else if (tx.cpl_tvalid && tx.mwr_tvalid)
`ifdef PCIE_TX_ARB_STRICT_CPL_EN
                    state_d = CPL;
`else
                    state_d = last_mwr_q ? CPL : MWR;
`endif
            end
            CFG: begin
                if (!tx.tx_cfg_req)
                    state_d = IDLE;
            end
            CPL, MWR: begin
                if (out_fire) begin
                    if (out_beat.tlast) begin
                        state_d    = IDLE;
                        last_mwr_d = (state_q == MWR);
                        cnt_d      = '0;
                    end else begin
                        // Oversize TLPs still pass through; the flag only reports them.
                        if (cnt_q == CNT_MAX)
                            err_d = 1'b1;
                        if (cnt_q != CNT_SAT)
                            cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q    <= IDLE;
            last_mwr_q <= 1'b1;
            cnt_q      <= '0;
            gnt_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_mwr_q <= last_mwr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= (state_d == CFG);
            err_q      <= err_d;
        end
    end

    assign tx.cpl_tready       = cpl_rdy;
    assign tx.mwr_tready       = mwr_rdy;
    assign tx.s_axis_tx_tvalid = out_vld;
    assign tx.s_axis_tx_tdata  = out_beat.tdata;
    assign tx.s_axis_tx_tkeep  = out_beat.tkeep;
    assign tx.s_axis_tx_tlast  = out_beat.tlast;
    assign tx.s_axis_tx_tuser  = out_beat.tuser;
    assign tx.tx_cfg_gnt       = gnt_q;
    assign tx.tx_err           = err_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Randomized bench for pcie_tx_arbiter with a transaction-level owner/err model and per-source sequence scoreboard.
// Directed sections pin reset, first-grant timing, TLP order, cfg hand-over, oversize flag and async reset.
module tb_pcie_tx_arbiter;

    localparam int MAXB = 4;
`ifdef PCIE_TX_ARB_STRICT_CPL_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic user_clk = 1'b0;
    logic user_reset_n = 1'b0;
    always #5 user_clk = ~user_clk;

    pcie_tx_arbiter_if bus();

    pcie_tx_arbiter #(.MAX_BEATS(MAXB)) dut (
        .user_clk     (user_clk),
        .user_reset_n (user_reset_n),
        .tx           (bus)
    );

    int errors = 0;
    int checks = 0;

    // Source drivers: index 0 = cpl, 1 = mwr.
    int seq[2], idx[2], len[2], fixlen[2], tlp_left[2], acc_cnt[2], dlv_cnt[2], exp_seq[2];
    bit act[2], backlog[2];
    bit gaps, cfg_rand, cfg_val, rdy_val;
    int rdy_mode;

    // Reference model: who owns the channel, beats sent in the current TLP, sticky error.
    int m_own;      // 0 idle, 1 cfg, 2 cpl, 3 mwr
    bit m_last_mwr;
    int m_k;
    bit m_err;

    int cyc;
    bit sink_new;
    int winners[$];
    int starts[$];
    bit obs_fire, obs_tlast, obs_gnt, obs_err;
    int obs_src;

    function automatic void chk(string nm, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    function automatic logic [76:0] beat_of(int s);
        logic [63:0] d;
        d = {s[0], 31'(seq[s] * 3 + 1), 32'(seq[s])};
        return {d, 8'(seq[s] * 37 + s), (idx[s] == len[s] - 1), 4'(seq[s] + s * 5)};
    endfunction

    task automatic drive();
        bit v[2];
        for (int s = 0; s < 2; s++) begin
            if (!act[s] && tlp_left[s] != 0 && (backlog[s] || $urandom_range(0, 3) == 0)) begin
                act[s] = 1'b1;
                idx[s] = 0;
                len[s] = (fixlen[s] > 0) ? fixlen[s] : int'($urandom_range(1, 6));
                if (tlp_left[s] > 0) tlp_left[s]--;
            end
            v[s] = act[s] && (!gaps || $urandom_range(0, 3) != 0);
        end
        {bus.cpl_tdata, bus.cpl_tkeep, bus.cpl_tlast, bus.cpl_tuser} = beat_of(0);
        {bus.mwr_tdata, bus.mwr_tkeep, bus.mwr_tlast, bus.mwr_tuser} = beat_of(1);
        bus.cpl_tvalid = v[0];
        bus.mwr_tvalid = v[1];
        case (rdy_mode)
            0:       rdy_val = 1'b1;
            1:       rdy_val = ~rdy_val;
            default: rdy_val = 1'($urandom_range(0, 1));
        endcase
        bus.s_axis_tx_tready = rdy_val;
        if (cfg_rand && $urandom_range(0, 19) == 0) cfg_val = ~cfg_val;
        bus.tx_cfg_req = cfg_val;
    endtask

    task automatic observe();
        logic [76:0]  cb, mb, eb;
        logic [127:0] expv, gotv;
        bit e_vld, e_crdy, e_mrdy, cv, mv, rdy, acc;
        cyc++;
        cb  = {bus.cpl_tdata, bus.cpl_tkeep, bus.cpl_tlast, bus.cpl_tuser};
        mb  = {bus.mwr_tdata, bus.mwr_tkeep, bus.mwr_tlast, bus.mwr_tuser};
        cv  = bus.cpl_tvalid;
        mv  = bus.mwr_tvalid;
        rdy = bus.s_axis_tx_tready;
        if (!user_reset_n) begin
            m_own = 0; m_last_mwr = 1'b1; m_k = 0; m_err = 1'b0; sink_new = 1'b1;
        end
        eb = '0; e_vld = 1'b0; e_crdy = 1'b0; e_mrdy = 1'b0;
        if (m_own == 2) begin eb = cb; e_vld = cv; e_crdy = rdy; end
        if (m_own == 3) begin eb = mb; e_vld = mv; e_mrdy = rdy; end
        expv = {46'b0, e_vld, e_crdy, e_mrdy, (m_own == 1), m_err, eb};
        gotv = {46'b0, bus.s_axis_tx_tvalid, bus.cpl_tready, bus.mwr_tready, bus.tx_cfg_gnt, bus.tx_err,
                bus.s_axis_tx_tdata, bus.s_axis_tx_tkeep, bus.s_axis_tx_tlast, bus.s_axis_tx_tuser};
        chk("outputs", gotv, expv);

        obs_fire  = bus.s_axis_tx_tvalid && bus.s_axis_tx_tready;
        obs_tlast = obs_fire && bus.s_axis_tx_tlast;
        obs_src   = int'(bus.s_axis_tx_tdata[63]);
        obs_gnt   = bus.tx_cfg_gnt;
        obs_err   = bus.tx_err;
        if (obs_fire) begin
            chk("seq", 128'(bus.s_axis_tx_tdata[31:0]), 128'(32'(exp_seq[obs_src])));
            exp_seq[obs_src] = int'(bus.s_axis_tx_tdata[31:0]) + 1;
            dlv_cnt[obs_src]++;
            if (sink_new) begin
                winners.push_back(obs_src);
                starts.push_back(cyc);
            end
            sink_new = bus.s_axis_tx_tlast;
        end

        for (int s = 0; s < 2; s++) begin
            acc = (s == 0) ? (bus.cpl_tvalid && bus.cpl_tready) : (bus.mwr_tvalid && bus.mwr_tready);
            if (acc) begin
                acc_cnt[s]++;
                seq[s]++;
                idx[s]++;
                if (idx[s] >= len[s]) act[s] = 1'b0;
            end
        end

        if (user_reset_n) begin
            case (m_own)
                0: begin
                    if (bus.tx_cfg_req)    m_own = 1;
                    else if (cv && !mv)    m_own = 2;
                    else if (mv && !cv)    m_own = 3;
                    else if (cv && mv)     m_own = (STRICT || m_last_mwr) ? 2 : 3;
                end
                1: if (!bus.tx_cfg_req) m_own = 0;
                default: begin
                    if (e_vld && rdy) begin
                        m_k++;
                        if (m_k > MAXB && !eb[4]) m_err = 1'b1;
                        if (eb[4]) begin
                            m_last_mwr = (m_own == 3);
                            m_k = 0;
                            m_own = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(negedge user_clk);
        observe();
        @(posedge user_clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        user_reset_n = 1'b0;
        act[0] = 1'b0;
        act[1] = 1'b0;
        repeat (3) cycle();
        #2;
        chk("reset_outputs",
            {46'b0, bus.s_axis_tx_tvalid, bus.cpl_tready, bus.mwr_tready, bus.tx_cfg_gnt, bus.tx_err,
             bus.s_axis_tx_tdata, bus.s_axis_tx_tkeep, bus.s_axis_tx_tlast, bus.s_axis_tx_tuser}, '0);
        user_reset_n = 1'b1;
        cyc = 0;
        winners.delete();
        starts.delete();
    endtask

    initial begin
        int first_fire, tl, g, bad, nf, e5, e6, base;
        int exp_w[4], exp_s[4];
        bit raised;

        for (int s = 0; s < 2; s++) begin
            seq[s] = 0; idx[s] = 0; len[s] = 1; fixlen[s] = 0; tlp_left[s] = 0;
            acc_cnt[s] = 0; dlv_cnt[s] = 0; exp_seq[s] = 0; act[s] = 1'b0; backlog[s] = 1'b0;
        end
        gaps = 1'b0; cfg_rand = 1'b0; cfg_val = 1'b0; rdy_val = 1'b1; rdy_mode = 0;
        m_own = 0; m_last_mwr = 1'b1; m_k = 0; m_err = 1'b0; cyc = 0; sink_new = 1'b1;
        drive();

        // Both sources hold a backlog of fixed-length TLPs: cpl 3 beats, mwr 2 beats.
        fixlen[0] = 3; fixlen[1] = 2; backlog[0] = 1'b1; backlog[1] = 1'b1;
        tlp_left[0] = -1; tlp_left[1] = -1;
        do_reset();
        first_fire = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (obs_fire && first_fire < 0) first_fire = cyc;
        end
        chk("first_beat_cycle", 128'(first_fire), 128'(2));
        if (STRICT) begin
            exp_w = '{0, 0, 0, 0}; exp_s = '{2, 6, 10, 14};
        end else begin
            exp_w = '{0, 1, 0, 1}; exp_s = '{2, 6, 9, 13};
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("winner%0d", i), 128'((winners.size() > i) ? winners[i] : 9), 128'(exp_w[i]));
            chk($sformatf("tlp_start%0d", i), 128'((starts.size() > i) ? starts[i] : -1), 128'(exp_s[i]));
        end

        // cfg request raised mid-TLP on 4-beat completions.
        tlp_left[1] = 0; fixlen[0] = 4;
        do_reset();
        raised = 1'b0; tl = -1; g = -1; bad = 0; base = acc_cnt[0];
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (raised && obs_tlast && tl < 0) tl = cyc;
            if (obs_gnt && g < 0) g = cyc;
            if (obs_gnt && bus.s_axis_tx_tvalid) bad++;
            if (!raised && acc_cnt[0] - base >= 2) begin
                raised = 1'b1; cfg_val = 1'b1; bus.tx_cfg_req = 1'b1;
            end
            if (i == 20) begin cfg_val = 1'b0; bus.tx_cfg_req = 1'b0; end
        end
        chk("cfg_tlast_cycle", 128'(tl), 128'(5));
        chk("cfg_gnt_cycle", 128'(g), 128'(7));
        chk("tvalid_during_gnt", 128'(bad), 128'(0));

        // Oversize TLP: 6 beats against MAX_BEATS=4.
        tlp_left[0] = 0;
        do_reset();
        tlp_left[1] = 1; fixlen[1] = 6; backlog[1] = 1'b1;
        nf = 0; e5 = 2; e6 = 2;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (obs_fire && obs_src == 1) begin
                nf++;
                if (nf == 5) e5 = int'(obs_err);
                if (nf == 6) e6 = int'(obs_err);
            end
        end
        chk("oversize_beats", 128'(nf), 128'(6));
        chk("err_at_beat5", 128'(e5), 128'(0));
        chk("err_at_beat6", 128'(e6), 128'(1));
        chk("err_sticky", 128'(bus.tx_err), 128'(1));

        // Asynchronous reset in the middle of a TLP.
        tlp_left[1] = 1; fixlen[1] = 4;
        base = acc_cnt[1];
        for (int i = 0; i < 20 && acc_cnt[1] - base < 2; i++) cycle();
        chk("pre_reset_vld", 128'(bus.s_axis_tx_tvalid), 128'(1));
        #1;
        user_reset_n = 1'b0;
        #1;
        chk("async_reset_vld", 128'(bus.s_axis_tx_tvalid), 128'(0));
        chk("async_reset_err", 128'(bus.tx_err), 128'(0));
        tlp_left[1] = 0;

        // Random traffic, then core tready toggling 1,0,1,0.
        fixlen[0] = 0; fixlen[1] = 0; backlog[0] = 1'b0; backlog[1] = 1'b0;
        do_reset();
        tlp_left[0] = -1; tlp_left[1] = -1; gaps = 1'b1; rdy_mode = 2; cfg_rand = 1'b1;
        repeat (3000) cycle();
        cfg_rand = 1'b0; cfg_val = 1'b0; rdy_mode = 1;
        repeat (400) cycle();
        tlp_left[0] = 0; tlp_left[1] = 0;
        for (int i = 0; i < 300 && (act[0] || act[1]); i++) cycle();
        repeat (4) cycle();
        chk("drained", 128'({act[0], act[1]}), 128'(0));
        chk("cpl_beats_delivered", 128'(dlv_cnt[0]), 128'(acc_cnt[0]));
        chk("mwr_beats_delivered", 128'(dlv_cnt[1]), 128'(acc_cnt[1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
